// File: rtl/uart_pkg.sv
// Shared UART definitions: the default line settings used by both the transmitter
// and the receiver, and the receiver state encoding.
package uart_pkg;

  // Both ends of the link read these, so they always run at the same rate.
  localparam int UART_CLK_FREQ = 10_000_000;
  localparam int UART_BAUDRATE = 115_200;

  // Width of the receiver bit-period counter; it covers clks_per_bit up to 4095.
  localparam int UART_CNT_W = 12;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for one asynchronous input.
// RESET_VAL sets the level both flops take in reset. The default is 1, which is the
// idle level of a UART line, so a reset never looks like a start bit.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // The first flop may go metastable. The second flop gives it a full cycle to settle.
  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  // Both synchroniser stages are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver.
// The line is synchronised, the start bit is confirmed at mid-bit, and the data and
// stop bits are then sampled once per bit period. A good frame gives a one-cycle
// data_valid pulse. A low stop bit gives a one-cycle frame_error pulse, and the FSM
// then waits for the line to return high.
//
// state        | meaning
// -------------+---------------------------------------------------------------
// RX_IDLE      | line idle; waiting for rx_s low
// RX_START     | half a bit after the falling edge; recheck low (glitch reject)
// RX_DATA      | sample 8 data bits LSB first, one per bit period
// RX_STOP      | sample the stop bit; publish the byte or flag a frame error
// RX_WAIT_HIGH | after a framing error or break; hold until the line is high
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_freq = UART_CLK_FREQ,
  parameter int baudrate = UART_BAUDRATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       input_rx,
  output logic [7:0] data_byte,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int clks_per_bit = clk_freq / baudrate;
  localparam int half_bit     = clks_per_bit / 2;

  // Terminal-count values: a period has expired when the counter equals limit-1.
  localparam logic [UART_CNT_W-1:0] BIT_LAST  = UART_CNT_W'(clks_per_bit - 1);
  localparam logic [UART_CNT_W-1:0] HALF_LAST = UART_CNT_W'(half_bit - 1);

  logic rx_s;

  rx_state_e             state_q,       state_d;
  logic [UART_CNT_W-1:0] cnt_q,         cnt_d;
  logic [2:0]            bit_idx_q,     bit_idx_d;
  logic [7:0]            shift_q,       shift_d;
  logic [7:0]            data_byte_q,   data_byte_d;
  logic                  data_valid_q,  data_valid_d;
  logic                  frame_error_q, frame_error_d;

  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (input_rx),
    .sync_out (rx_s)
  );

  // Next-state logic. The counter restarts at 0 on every state entry. Pulses
  // default to 0, so each one is high for exactly one cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + UART_CNT_W'(1);
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    data_byte_d   = data_byte_q;
    data_valid_d  = 1'b0;
    frame_error_d = 1'b0;

    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = RX_START;
        end
      end

      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = RX_DATA;
            bit_idx_d = 3'd0;
          end else begin
            // The line went high again before mid-bit, so this was a glitch.
            state_d = RX_IDLE;
          end
        end
      end

      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d        = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end
      end

      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            // Return to idle at mid-stop-bit, so a start edge that follows
            // straight after the stop bit is still seen.
            data_byte_d  = shift_q;
            data_valid_d = 1'b1;
            state_d      = RX_IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = RX_WAIT_HIGH;
          end
        end
      end

      RX_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = RX_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

  // FSM, counter, shift register and registered outputs. A reset during a frame
  // drops the frame and produces no pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RX_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'h00;
      data_byte_q   <= 8'h00;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      data_byte_q   <= data_byte_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign data_byte   = data_byte_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != RX_IDLE);

endmodule
